// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: RV32I MEM-stage load/store unit with byte lanes, load extension and sticky fault capture
module lsu_mem_stage #(
    parameter int MEM_WORDS = 'h901
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd_in,
    input  logic        clear_fault,
    output logic        ram_is_store,
    output logic        ram_is_load,
    output logic [3:0]  ram_w_enable,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_w_data,
    input  logic [31:0] ram_r_data,
    output logic        load_valid,
    output logic [31:0] load_data,
    output logic [4:0]  rd_out,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic [31:0] fault_addr
);
    logic        acc, bad_f3, mis, oor, fault_now;
    logic [1:0]  cause_now;
    logic [3:0]  st_mask;
    logic        p_load;
    logic [2:0]  p_f3;
    logic [1:0]  p_off;
    logic [7:0]  lb;
    logic [15:0] lh;

    always_comb begin
        acc = valid & (is_load | is_store);
        bad_f3 = (is_load & is_store)
               | (is_load & (funct3 == 3'b011 || funct3[2:1] == 2'b11))
               | (is_store & (funct3[2] || funct3[1:0] == 2'b11));
        mis = (funct3[1:0] == 2'b01 && addr[0]) || (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
        ram_addr = {2'b00, addr[31:2]};
        oor = ram_addr >= 32'(MEM_WORDS);
        cause_now = !acc ? 2'b00 : bad_f3 ? 2'b11 : mis ? 2'b01 : oor ? 2'b10 : 2'b00;
        fault_now = |cause_now;
        st_mask = funct3[1:0] == 2'b00 ? 4'b0001 << addr[1:0]
                : funct3[1:0] == 2'b01 ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        ram_is_store = ~rst & acc & is_store & ~fault_now;
        ram_is_load = ~rst & acc & is_load & ~fault_now;
        ram_w_enable = ram_is_store ? st_mask : 4'b0000;
        ram_w_data = funct3[1:0] == 2'b00 ? {4{store_data[7:0]}}
                   : funct3[1:0] == 2'b01 ? {2{store_data[15:0]}} : store_data;
        lb = ram_r_data[{p_off, 3'b000} +: 8];
        lh = p_off[1] ? ram_r_data[31:16] : ram_r_data[15:0];
        load_valid = p_load;
        load_data = !p_load ? 32'd0
                  : p_f3[1:0] == 2'b00 ? {{24{lb[7] & ~p_f3[2]}}, lb}
                  : p_f3[1:0] == 2'b01 ? {{16{lh[15] & ~p_f3[2]}}, lh} : ram_r_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_load      <= 1'b0;
            p_f3        <= 3'b000;
            p_off       <= 2'b00;
            rd_out      <= 5'd0;
            fault       <= 1'b0;
            fault_cause <= 2'b00;
            fault_addr  <= 32'd0;
        end else begin
            p_load <= acc & is_load & ~fault_now;
            p_f3   <= funct3;
            p_off  <= addr[1:0];
            rd_out <= rd_in;
            if (fault_now && (!fault || clear_fault)) begin
                fault       <= 1'b1;
                fault_cause <= cause_now;
                fault_addr  <= addr;
            end else if (clear_fault) begin
                fault <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb_lsu_mem_stage: table-driven check of lsu_mem_stage against a behavioural word RAM
module tb_lsu_mem_stage;
    logic        clk = 1'b0;
    logic        rst, valid, is_load, is_store, clear_fault;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data, ram_addr, ram_w_data, ram_r_data, load_data, fault_addr;
    logic [4:0]  rd_in, rd_out;
    logic        ram_is_store, ram_is_load, load_valid, fault;
    logic [3:0]  ram_w_enable;
    logic [1:0]  fault_cause;
    logic [31:0] mem [0:4095];
    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [4:0]  ctl;
        logic [2:0]  f3;
        logic [31:0] a, sd;
        logic [4:0]  rd;
        logic [1:0]  e_sl;
        logic [3:0]  e_m;
        logic [31:0] e_wa, e_wd;
        logic        e_lv;
        logic [31:0] e_ld;
        logic [4:0]  e_rd;
        logic        e_f;
        logic [1:0]  e_c;
        logic [31:0] e_fa;
    } vec_t;

    vec_t tbl [31];

    always #5 clk = ~clk;

    lsu_mem_stage dut (
        .clk(clk), .rst(rst), .valid(valid), .is_load(is_load), .is_store(is_store),
        .funct3(funct3), .addr(addr), .store_data(store_data), .rd_in(rd_in),
        .clear_fault(clear_fault), .ram_is_store(ram_is_store), .ram_is_load(ram_is_load),
        .ram_w_enable(ram_w_enable), .ram_addr(ram_addr), .ram_w_data(ram_w_data),
        .ram_r_data(ram_r_data), .load_valid(load_valid), .load_data(load_data),
        .rd_out(rd_out), .fault(fault), .fault_cause(fault_cause), .fault_addr(fault_addr)
    );

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (ram_is_store && ram_w_enable[i]) mem[ram_addr[11:0]][8*i +: 8] <= ram_w_data[8*i +: 8];
        if (ram_is_load) ram_r_data <= mem[ram_addr[11:0]];
    end

    task automatic chk(input string name, input int idx, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic step(input vec_t v, input int idx);
        {rst, valid, is_load, is_store, clear_fault} = v.ctl;
        funct3 = v.f3; addr = v.a; store_data = v.sd; rd_in = v.rd;
        #1;
        chk("request", idx, 128'({ram_is_store, ram_is_load, ram_w_enable, ram_addr, ram_w_data}),
            128'({v.e_sl, v.e_m, v.e_wa, v.e_wd}));
        @(posedge clk);
        #1;
        chk("response", idx, 128'({load_valid, load_data, rd_out}), 128'({v.e_lv, v.e_ld, v.e_rd}));
        chk("fault", idx, 128'({fault, fault_cause, fault_addr}), 128'({v.e_f, v.e_c, v.e_fa}));
    endtask

    initial begin
        tbl = '{
            '{5'b11010, 3'b010, 32'h10, 32'h55, 5'd3, 2'b00, 4'h0, 32'h4, 32'h55, 1'b0, 32'h0, 5'd0, 1'b0, 2'b00, 32'h0},
            '{5'b01010, 3'b010, 32'h0, 32'h0, 5'd0, 2'b10, 4'hF, 32'h0, 32'h0, 1'b0, 32'h0, 5'd0, 1'b0, 2'b00, 32'h0},
            '{5'b01010, 3'b010, 32'h4, 32'h11223344, 5'd0, 2'b10, 4'hF, 32'h1, 32'h11223344, 1'b0, 32'h0, 5'd0, 1'b0, 2'b00, 32'h0},
            '{5'b01010, 3'b010, 32'h2400, 32'hCAFEF00D, 5'd0, 2'b10, 4'hF, 32'h900, 32'hCAFEF00D, 1'b0, 32'h0, 5'd0, 1'b0, 2'b00, 32'h0},
            '{5'b01010, 3'b010, 32'h10, 32'hDEADBEEF, 5'd1, 2'b10, 4'hF, 32'h4, 32'hDEADBEEF, 1'b0, 32'h0, 5'd1, 1'b0, 2'b00, 32'h0},
            '{5'b01100, 3'b010, 32'h10, 32'h0, 5'd5, 2'b01, 4'h0, 32'h4, 32'h0, 1'b1, 32'hDEADBEEF, 5'd5, 1'b0, 2'b00, 32'h0},
            '{5'b01010, 3'b000, 32'h13, 32'h80, 5'd2, 2'b10, 4'h8, 32'h4, 32'h80808080, 1'b0, 32'h0, 5'd2, 1'b0, 2'b00, 32'h0},
            '{5'b01100, 3'b000, 32'h13, 32'h0, 5'd6, 2'b01, 4'h0, 32'h4, 32'h0, 1'b1, 32'hFFFFFF80, 5'd6, 1'b0, 2'b00, 32'h0},
            '{5'b01100, 3'b100, 32'h13, 32'h0, 5'd7, 2'b01, 4'h0, 32'h4, 32'h0, 1'b1, 32'h00000080, 5'd7, 1'b0, 2'b00, 32'h0},
            '{5'b01010, 3'b001, 32'h12, 32'h8001, 5'd4, 2'b10, 4'hC, 32'h4, 32'h80018001, 1'b0, 32'h0, 5'd4, 1'b0, 2'b00, 32'h0},
            '{5'b01100, 3'b001, 32'h12, 32'h0, 5'd8, 2'b01, 4'h0, 32'h4, 32'h0, 1'b1, 32'hFFFF8001, 5'd8, 1'b0, 2'b00, 32'h0},
            '{5'b01100, 3'b101, 32'h12, 32'h0, 5'd9, 2'b01, 4'h0, 32'h4, 32'h0, 1'b1, 32'h00008001, 5'd9, 1'b0, 2'b00, 32'h0},
            '{5'b01100, 3'b000, 32'h10, 32'h0, 5'd10, 2'b01, 4'h0, 32'h4, 32'h0, 1'b1, 32'hFFFFFFEF, 5'd10, 1'b0, 2'b00, 32'h0},
            '{5'b01100, 3'b100, 32'h11, 32'h0, 5'd11, 2'b01, 4'h0, 32'h4, 32'h0, 1'b1, 32'h000000BE, 5'd11, 1'b0, 2'b00, 32'h0},
            '{5'b01100, 3'b001, 32'h10, 32'h0, 5'd12, 2'b01, 4'h0, 32'h4, 32'h0, 1'b1, 32'hFFFFBEEF, 5'd12, 1'b0, 2'b00, 32'h0},
            '{5'b01100, 3'b010, 32'h21, 32'h0, 5'd13, 2'b00, 4'h0, 32'h8, 32'h0, 1'b0, 32'h0, 5'd13, 1'b1, 2'b01, 32'h21},
            '{5'b01010, 3'b010, 32'h4000, 32'h12345678, 5'd0, 2'b00, 4'h0, 32'h1000, 32'h12345678, 1'b0, 32'h0, 5'd0, 1'b1, 2'b01, 32'h21},
            '{5'b00001, 3'b000, 32'h0, 32'h0, 5'd0, 2'b00, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, 5'd0, 1'b0, 2'b01, 32'h21},
            '{5'b01010, 3'b010, 32'h4000, 32'h12345678, 5'd0, 2'b00, 4'h0, 32'h1000, 32'h12345678, 1'b0, 32'h0, 5'd0, 1'b1, 2'b10, 32'h4000},
            '{5'b01101, 3'b011, 32'h8, 32'h0, 5'd14, 2'b00, 4'h0, 32'h2, 32'h0, 1'b0, 32'h0, 5'd14, 1'b1, 2'b11, 32'h8},
            '{5'b01111, 3'b010, 32'h4, 32'hFFFFFFFF, 5'd0, 2'b00, 4'h0, 32'h1, 32'hFFFFFFFF, 1'b0, 32'h0, 5'd0, 1'b1, 2'b11, 32'h4},
            '{5'b01100, 3'b010, 32'h4, 32'h0, 5'd15, 2'b01, 4'h0, 32'h1, 32'h0, 1'b1, 32'h11223344, 5'd15, 1'b1, 2'b11, 32'h4},
            '{5'b00011, 3'b010, 32'h4000, 32'h0, 5'd0, 2'b00, 4'h0, 32'h1000, 32'h0, 1'b0, 32'h0, 5'd0, 1'b0, 2'b11, 32'h4},
            '{5'b01100, 3'b010, 32'h2400, 32'h0, 5'd16, 2'b01, 4'h0, 32'h900, 32'h0, 1'b1, 32'hCAFEF00D, 5'd16, 1'b0, 2'b11, 32'h4},
            '{5'b01100, 3'b010, 32'h2404, 32'h0, 5'd17, 2'b00, 4'h0, 32'h901, 32'h0, 1'b0, 32'h0, 5'd17, 1'b1, 2'b10, 32'h2404},
            '{5'b01011, 3'b011, 32'h0, 32'h0, 5'd0, 2'b00, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, 5'd0, 1'b1, 2'b11, 32'h0},
            '{5'b01101, 3'b001, 32'h4001, 32'h0, 5'd18, 2'b00, 4'h0, 32'h1000, 32'h0, 1'b0, 32'h0, 5'd18, 1'b1, 2'b01, 32'h4001},
            '{5'b01101, 3'b110, 32'h4003, 32'h0, 5'd19, 2'b00, 4'h0, 32'h1000, 32'h0, 1'b0, 32'h0, 5'd19, 1'b1, 2'b11, 32'h4003},
            '{5'b01011, 3'b001, 32'h0, 32'hABCD, 5'd0, 2'b10, 4'h3, 32'h0, 32'hABCDABCD, 1'b0, 32'h0, 5'd0, 1'b0, 2'b11, 32'h4003},
            '{5'b01010, 3'b000, 32'h1, 32'h01, 5'd0, 2'b10, 4'h2, 32'h0, 32'h01010101, 1'b0, 32'h0, 5'd0, 1'b0, 2'b11, 32'h4003},
            '{5'b01100, 3'b010, 32'h0, 32'h0, 5'd20, 2'b01, 4'h0, 32'h0, 32'h0, 1'b1, 32'h000001CD, 5'd20, 1'b0, 2'b11, 32'h4003}
        };
        {rst, valid, is_load, is_store, clear_fault} = 5'b10000;
        funct3 = 3'b000; addr = 32'h0; store_data = 32'h0; rd_in = 5'd0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 31; i++) step(tbl[i], i);
        step('{5'b01100, 3'b010, 32'h1, 32'h0, 5'd21, 2'b00, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, 5'd21, 1'b1, 2'b01, 32'h1}, 100);
        step('{5'b01100, 3'b010, 32'h0, 32'h0, 5'd22, 2'b01, 4'h0, 32'h0, 32'h0, 1'b1, 32'h000001CD, 5'd22, 1'b1, 2'b01, 32'h1}, 101);
        step('{5'b01100, 3'b010, 32'h4, 32'h0, 5'd23, 2'b01, 4'h0, 32'h1, 32'h0, 1'b1, 32'h11223344, 5'd23, 1'b1, 2'b01, 32'h1}, 102);
        step('{5'b11100, 3'b010, 32'h8, 32'h0, 5'd24, 2'b00, 4'h0, 32'h2, 32'h0, 1'b0, 32'h0, 5'd0, 1'b0, 2'b00, 32'h0}, 103);
        step('{5'b00000, 3'b010, 32'hC, 32'h0, 5'd0, 2'b00, 4'h0, 32'h3, 32'h0, 1'b0, 32'h0, 5'd0, 1'b0, 2'b00, 32'h0}, 104);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
MEM-stage load/store unit of the five-stage RV32I pipeline, sitting directly upstream of the word-addressed data RAM. Turns a byte address plus funct3 into the RAM's word index, 4-bit byte-write mask and lane-shifted write data. It also holds the access attributes across the RAM's one-cycle synchronous read latency, so it can extract and sign/zero-extend the returned word for WB. Detects illegal, misaligned and out-of-range accesses, suppresses them, and records the first fault.

Parameters:
MEM_WORDS, 2305 ('h901), number of 32-bit words in the data RAM; word index >= MEM_WORDS is out of range.

Ports:
clk  in  1  pipeline clock
rst  in  1  synchronous active-high reset
valid  in  1  MEM-stage instruction valid this cycle
is_load  in  1  instruction is a load
is_store  in  1  instruction is a store
funct3  in  3  RV32I width/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU)
addr  in  32  byte address from EX
store_data  in  32  rs2 value, unaligned (value in low bits)
rd_in  in  5  destination register of the load
clear_fault  in  1  clears the sticky fault state
ram_is_store  out  1  RAM write strobe
ram_is_load  out  1  RAM read strobe
ram_w_enable  out  4  RAM byte lane mask
ram_addr  out  32  RAM word index, {2'b00, addr[31:2]}
ram_w_data  out  32  store_data replicated/shifted into lanes
ram_r_data  in  32  RAM read word, valid one cycle after ram_is_load
load_valid  out  1  load_data/rd_out valid (WB write enable)
load_data  out  32  extended load result
rd_out  out  5  destination register aligned with load_data
fault  out  1  sticky: a faulting access occurred
fault_cause  out  2  01 misaligned, 10 out of range, 11 illegal encoding
fault_addr  out  32  byte address of the first faulting access

Behaviour:
- Request side is combinational on valid/is_load/is_store/funct3/addr; the RAM samples it at the next posedge.
- Byte store: mask = 1<<addr[1:0]; data = {4{sd[7:0]}}.
- Half store: mask = 0011 or 1100 by addr[1]; data = {2{sd[15:0]}}.
- Word store: mask = 1111; data = sd.
- Loads drive ram_is_load=1, ram_w_enable=0000.
- Illegal (cause 11):
  - is_load && is_store;
  - load funct3 in {011,110,111};
  - store funct3 not in {000,001,010}.
- Misaligned (cause 01):
  - half access with addr[0]=1;
  - word access with addr[1:0]!=00.
- Out of range (cause 10): addr[31:2] >= MEM_WORDS.
- Fault priority: 11 > 01 > 10.
- A faulting access with valid=1 forces ram_is_load=ram_is_store=0 and ram_w_enable=0000. No RAM side effect.
- valid=0: all RAM strobes 0; no fault check.
- Response stage: on posedge, register p_load = valid & is_load & ~fault_now, plus funct3, addr[1:0] and rd_in.
  - load_valid = p_load (registered), so results appear exactly 1 cycle after request.
  - load_data is combinational from ram_r_data and the registered funct3/offset:
    - byte: lane addr[1:0], sign (000) or zero (100) extended;
    - half: lane addr[1], sign (001) or zero (101) extended;
    - word: unchanged.
  - load_data = 0 when load_valid=0.
- Back-to-back loads/stores every cycle are supported with no stall.
- A load to the word stored in the previous cycle returns the new data, because the RAM write has already committed.
- Fault register:
  - on the first fault with fault=0, set fault=1 and latch fault_cause and fault_addr on that posedge;
  - later faults are ignored until clear_fault;
  - clear_fault and a new fault in the same cycle: the new fault is latched.
- Reset values: load_valid=0, p_load=0, rd_out=0, load_data=0, fault=0, fault_cause=00, fault_addr=0.
- RAM strobes are 0 while rst=1.
- Reset asserted mid-load drops the pending response; load_valid=0 on the next cycle.

Test Plan:
1. SW 0xDEADBEEF at 0x10, then LW 0x10 -> mask 1111, ram_addr 4; next cycle load_valid=1, load_data=0xDEADBEEF.
2. SB 0x80 at 0x13, then LB 0x13 / LBU 0x13 -> mask 1000, ram_w_data=0x80808080; responses 0xFFFFFF80 / 0x00000080.
3. SH 0x8001 at 0x12, then LH/LHU 0x12 -> mask 1100; responses 0xFFFF8001 / 0x00008001; rd_out matches rd_in delayed 1 cycle.
4. LW at 0x21 -> no RAM strobe, load_valid stays 0, fault=1, cause 01, fault_addr=0x21; then SW at 0x4000 -> fault unchanged; clear_fault, repeat SW 0x4000 -> cause 10, fault_addr 0x4000.
5. Load funct3=011 with is_store=0 -> cause 11. Separately, is_load=is_store=1 -> cause 11, RAM untouched.
6. Four consecutive LWs to 0x0,0x4,0x8,0xC with rst asserted on the 3rd -> first two responses delivered; after reset deassertion load_valid=0 and all outputs at reset values.
